// File: rtl/sdram_arbiter.sv
// Purpose: shares one sdram controller between instruction fetch (read-only) and the CPU data
//          port (read/write); retries commands the controller dropped because of its own refresh.
// Latency: command strobe 1 cycle after grant; read ack 6 cycles after the strobe (idle controller).
// Backpressure: requests are level-held until ack; one transaction in flight, the other port waits.
//
// Optional feature macro: SDRAM_ARB_WBUF_EN -- one-entry posted write buffer for the data port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_addr/i_req -> i_ack/i_rdata            fetch port (reads only)
//   d_addr/d_wdata/d_we/d_req -> d_ack/d_rdata  data port (reads and writes)
//   m_addr/m_wdata/m_read_req/m_write_req    command side toward the controller
//   m_busy/m_read_ready/m_rdata              status and read data from the controller
module sdram_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_req,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_we,
  input  logic              d_req,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read_req,
  output logic              m_write_req,
  input  logic              m_busy,
  input  logic              m_read_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_CHECK, S_WAIT_RD, S_WAIT_WR_H, S_WAIT_WR_L
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              gnt_i_q, gnt_i_d;      // 1: fetch owns the current transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_c, d_ack_c;
  logic              d_elig, fetch_first;
  logic [3:0]        starve_inc;

`ifdef SDRAM_ARB_WBUF_EN
  logic              wb_vld_q, wb_vld_d;
  logic              wb_ack_q, wb_ack_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic              wb_take;

  // Writes never go straight to the controller; only reads compete for a direct grant.
  assign wb_take = d_req && d_we && !wb_vld_q && !wb_ack_q;
  assign d_elig  = d_req && !d_we;
`else
  assign d_elig  = d_req;
`endif

  assign fetch_first = i_req && (starve_q == LIMIT);
  // Saturates so a forced write-buffer drain cannot push the count past the limit.
  assign starve_inc  = !i_req ? 4'd0 : (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    starve_d  = i_req ? starve_q : 4'd0;
    gnt_i_d   = gnt_i_q;
    we_d      = we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_c   = 1'b0;
    d_ack_c   = 1'b0;
`ifdef SDRAM_ARB_WBUF_EN
    wb_vld_d   = wb_vld_q;
    wb_ack_d   = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_wdata_d = wb_wdata_q;
`endif
    // Under reset nothing may be acked or captured, even if a stale completion arrives.
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
`ifdef SDRAM_ARB_WBUF_EN
          if (wb_take) begin
            // Absorb the write and grant nothing this cycle, so no read can overtake it.
            wb_vld_d   = 1'b1;
            wb_ack_d   = 1'b1;
            wb_addr_d  = d_addr;
            wb_wdata_d = d_wdata;
          end else if (wb_vld_q) begin
            gnt_i_d   = 1'b0;
            we_d      = 1'b1;
            m_addr_d  = wb_addr_q;
            m_wdata_d = wb_wdata_q;
            starve_d  = starve_inc;
            state_d   = S_ISSUE;
          end else
`endif
          if (d_elig && !fetch_first) begin
            gnt_i_d   = 1'b0;
            we_d      = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            starve_d  = starve_inc;
            state_d   = S_ISSUE;
          end else if (i_req) begin
            gnt_i_d   = 1'b1;
            we_d      = 1'b0;
            m_addr_d  = i_addr;
            starve_d  = 4'd0;
            state_d   = S_ISSUE;
          end
        end
        S_ISSUE: state_d = S_CHECK;
        S_CHECK: begin
          // Busy here means refresh started before our strobe; the command was dropped.
          if (m_busy) begin
            state_d = S_IDLE;
          end else if (we_q) begin
            state_d = S_WAIT_WR_H;
`ifdef SDRAM_ARB_WBUF_EN
            wb_vld_d = 1'b0;
`endif
          end else begin
            state_d = S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (m_read_ready) begin
            if (gnt_i_q) begin
              i_ack_c   = 1'b1;
              i_rdata_d = m_rdata;
            end else begin
              d_ack_c   = 1'b1;
              d_rdata_d = m_rdata;
            end
            state_d = S_IDLE;
          end
        end
        S_WAIT_WR_H: begin
          if (m_busy) state_d = S_WAIT_WR_L;
        end
        S_WAIT_WR_L: begin
          if (!m_busy) begin
`ifndef SDRAM_ARB_WBUF_EN
            d_ack_c = 1'b1;
`endif
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      starve_q  <= 4'd0;
      gnt_i_q   <= 1'b0;
      we_q      <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      gnt_i_q   <= gnt_i_d;
      we_q      <= we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef SDRAM_ARB_WBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_q   <= 1'b0;
      wb_ack_q   <= 1'b0;
      wb_addr_q  <= '0;
      wb_wdata_q <= '0;
    end else begin
      wb_vld_q   <= wb_vld_d;
      wb_ack_q   <= wb_ack_d;
      wb_addr_q  <= wb_addr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign d_ack = d_ack_c | (wb_ack_q & ~rst);
`else
  assign d_ack = d_ack_c;
`endif

  assign i_ack       = i_ack_c;
  // Read data passes through in the ack cycle and is held from the register afterwards.
  assign i_rdata     = i_rdata_d;
  assign d_rdata     = d_rdata_d;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_read_req  = !rst && (state_q == S_ISSUE) && !we_q;
  assign m_write_req = !rst && (state_q == S_ISSUE) && we_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Purpose: directed self-checking bench for sdram_arbiter with a small sdram controller model.
// Latency: controller completes 5 cycles after accepting; read_ready lands 6 cycles after strobe.
// Backpressure: requesters hold req until ack and drop it in the ack cycle.
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
`ifdef SDRAM_ARB_WBUF_EN
  localparam int WR_ACK_LAT   = 1;
  localparam int FETCH_AFT_WR = 16;
`else
  localparam int WR_ACK_LAT   = 8;
  localparam int FETCH_AFT_WR = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic          i_req, i_ack, d_req, d_ack, d_we;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata;
  logic          m_read_req, m_write_req;
  logic          m_busy = 1'b0;
  logic          m_read_ready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          ref_go;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_req(i_req), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_req(d_req),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read_req(m_read_req), .m_write_req(m_write_req),
    .m_busy(m_busy), .m_read_ready(m_read_ready), .m_rdata(m_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 24'h000123) return 16'hBEEF;
    return a[15:0] ^ 16'h5A00;
  endfunction

  // Controller model: registered busy lags its internal state by one cycle.
  logic          c_busy = 1'b0;
  int            c_cnt = 0;
  logic          c_rd = 1'b0;
  logic          c_wr = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  bit   [DW-1:0] wmem [0:1023];
  bit            wvld [0:1023];

  always @(posedge clk) begin
    m_busy       <= c_busy;
    m_read_ready <= 1'b0;
    if (!c_busy && (m_read_req || m_write_req)) begin
      c_busy  <= 1'b1;
      c_cnt   <= 5;
      c_rd    <= m_read_req;
      c_wr    <= m_write_req;
      c_addr  <= m_addr;
      c_wdata <= m_wdata;
    end else if (!c_busy && ref_go) begin
      c_busy <= 1'b1;
      c_cnt  <= 2;
      c_rd   <= 1'b0;
      c_wr   <= 1'b0;
    end else if (c_busy) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        c_busy <= 1'b0;
        if (c_rd) begin
          m_read_ready <= 1'b1;
          m_rdata      <= wvld[c_addr[9:0]] ? wmem[c_addr[9:0]] : init_val(c_addr);
        end
        if (c_wr) begin
          wmem[c_addr[9:0]] <= c_wdata;
          wvld[c_addr[9:0]] <= 1'b1;
        end
      end
    end
  end

  // Monitor: cyc numbers the cycle; counts strobes and acks of the cycle that just ended.
  int            cyc = 0;
  int            n_rd = 0, n_wr = 0, n_iack = 0, n_dack = 0, n_overlap = 0;
  int            last_rd_cyc = 0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [DW-1:0] last_wr_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_read_req) begin
      n_rd <= n_rd + 1; last_rd_addr <= m_addr; last_rd_cyc <= cyc;
    end
    if (m_write_req) begin
      n_wr <= n_wr + 1; last_wr_addr <= m_addr; last_wr_data <= m_wdata;
    end
    if (i_ack) n_iack <= n_iack + 1;
    if (d_ack) n_dack <= n_dack + 1;
    if (i_ack && d_ack) n_overlap <= n_overlap + 1;
  end

  // Waits for the ack of one port, then drops that port's request. at = -1 on timeout.
  task automatic wait_ack(input bit fetch, input int budget, output int at, output logic [DW-1:0] dat);
    at = -1;
    dat = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fetch ? i_ack : d_ack) begin
        at  = cyc;
        dat = fetch ? i_rdata : d_rdata;
        break;
      end
    end
    if (fetch) i_req = 1'b0; else d_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ref_go = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i_ack, d_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_acks: got %b expected 00", {i_ack, d_ack});
    end
    checks++;
    if ({m_read_req, m_write_req} !== 2'b00) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00", {m_read_req, m_write_req});
    end
    checks++;
    if ({m_addr, m_wdata} !== '0) begin
      errors++; $display("FAIL reset_m_bus: got addr %h wdata %h expected 0", m_addr, m_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata: got i %h d %h expected 0", i_rdata, d_rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int req_c, at, s_rd, s_iack;
    logic [DW-1:0] dat;
    s_rd = n_rd; s_iack = n_iack;
    d_addr = 24'h000123; d_we = 1'b0; d_req = 1'b1; req_c = cyc;
    wait_ack(1'b0, 30, at, dat);
    checks++;
    if (at - req_c !== 7) begin
      errors++; $display("FAIL rd_latency: got %0d expected 7", at - req_c);
    end
    checks++;
    if (dat !== 16'hBEEF) begin
      errors++; $display("FAIL rd_data: got %h expected beef", dat);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_rd - s_rd !== 1) begin
      errors++; $display("FAIL rd_strobes: got %0d expected 1", n_rd - s_rd);
    end
    checks++;
    if (last_rd_addr !== 24'h000123 || last_rd_cyc !== req_c + 1) begin
      errors++; $display("FAIL rd_cmd: got addr %h cyc %0d expected 000123 cyc %0d",
                         last_rd_addr, last_rd_cyc, req_c + 1);
    end
    checks++;
    if (d_rdata !== 16'hBEEF || n_iack !== s_iack) begin
      errors++; $display("FAIL rd_hold: got d_rdata %h i_acks %0d expected beef %0d",
                         d_rdata, n_iack - s_iack, 0);
    end
  endtask

  task automatic test_write_then_fetch();
    int req_c, at, at2, s_wr, s_dack;
    bit seen_hi;
    logic busy_before, busy_at_ack;
    logic [DW-1:0] dat;
    @(negedge clk);
    s_wr = n_wr; s_dack = n_dack;
    d_addr = 24'h000200; d_wdata = 16'h1234; d_we = 1'b1; d_req = 1'b1; req_c = cyc;
    at = -1; seen_hi = 1'b0; busy_before = 1'b0; busy_at_ack = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (d_ack) begin
        at = cyc; busy_at_ack = m_busy;
        break;
      end
      if (m_busy) seen_hi = 1'b1;
      busy_before = m_busy;
    end
    d_req = 1'b0; d_we = 1'b0;
    checks++;
    if (at - req_c !== WR_ACK_LAT) begin
      errors++; $display("FAIL wr_ack_latency: got %0d expected %0d", at - req_c, WR_ACK_LAT);
    end
`ifndef SDRAM_ARB_WBUF_EN
    checks++;
    if (seen_hi !== 1'b1 || busy_before !== 1'b1) begin
      errors++; $display("FAIL wr_ack_early: busy seen %b busy before ack %b expected 1 1",
                         seen_hi, busy_before);
    end
    checks++;
    if (busy_at_ack !== 1'b0) begin
      errors++; $display("FAIL wr_ack_busy: got m_busy %b at ack expected 0", busy_at_ack);
    end
`endif
    // Fetch the same address straight away; it must see the written data.
    i_addr = 24'h000200; i_req = 1'b1;
    wait_ack(1'b1, 40, at2, dat);
    checks++;
    if (at2 - at !== FETCH_AFT_WR) begin
      errors++; $display("FAIL fetch_after_wr_latency: got %0d expected %0d", at2 - at, FETCH_AFT_WR);
    end
    checks++;
    if (dat !== 16'h1234) begin
      errors++; $display("FAIL fetch_after_wr_data: got %h expected 1234", dat);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_wr - s_wr !== 1 || last_wr_addr !== 24'h000200 || last_wr_data !== 16'h1234) begin
      errors++; $display("FAIL wr_cmd: got %0d strobes addr %h data %h expected 1 000200 1234",
                         n_wr - s_wr, last_wr_addr, last_wr_data);
    end
    checks++;
    if (n_dack - s_dack !== 1) begin
      errors++; $display("FAIL wr_ack_count: got %0d expected 1", n_dack - s_dack);
    end
  endtask

  task automatic test_refresh_retry();
    int req_c, at, s_rd, s_dack;
    logic [DW-1:0] dat;
    repeat (2) @(negedge clk);
    s_rd = n_rd; s_dack = n_dack;
    // Refresh starts in the grant cycle, so the first strobe lands on a busy controller.
    d_addr = 24'h000345; d_we = 1'b0; d_req = 1'b1; ref_go = 1'b1; req_c = cyc;
    @(negedge clk);
    ref_go = 1'b0;
    wait_ack(1'b0, 40, at, dat);
    checks++;
    if (at - req_c !== 10) begin
      errors++; $display("FAIL refresh_latency: got %0d expected 10", at - req_c);
    end
    checks++;
    if (dat !== init_val(24'h000345)) begin
      errors++; $display("FAIL refresh_data: got %h expected %h", dat, init_val(24'h000345));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_rd - s_rd !== 2) begin
      errors++; $display("FAIL refresh_reissue: got %0d strobes expected 2", n_rd - s_rd);
    end
    checks++;
    if (n_dack - s_dack !== 1) begin
      errors++; $display("FAIL refresh_ack_count: got %0d expected 1", n_dack - s_dack);
    end
  endtask

  task automatic test_starvation();
    byte ord [10];
    byte exp_c;
    int  n;
    repeat (2) @(negedge clk);
    i_addr = 24'h000040; d_addr = 24'h000050; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1; n = 0;
    for (int k = 0; k < 400 && n < 10; k++) begin
      @(negedge clk);
      if (i_ack) begin
        ord[n] = "I"; n++;
        checks++;
        if (i_rdata !== init_val(24'h000040)) begin
          errors++; $display("FAIL starve_i_data: got %h expected %h", i_rdata, init_val(24'h000040));
        end
      end
      if (d_ack && n < 10) begin
        ord[n] = "D"; n++;
        checks++;
        if (d_rdata !== init_val(24'h000050)) begin
          errors++; $display("FAIL starve_d_data: got %h expected %h", d_rdata, init_val(24'h000050));
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n !== 10) begin
      errors++; $display("FAIL starve_count: got %0d acks expected 10", n);
    end
    for (int p = 0; p < 10; p++) begin
      exp_c = (p % 5 == 4) ? "I" : "D";
      checks++;
      if (ord[p] !== exp_c) begin
        errors++; $display("FAIL starve_order[%0d]: got %c expected %c", p, ord[p], exp_c);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int c0, at, s_rd, s_dack;
    logic stale_ack;
    logic [DW-1:0] stale_rdata, dat;
    repeat (3) @(negedge clk);
    s_rd = n_rd; s_dack = n_dack;
    d_addr = 24'h0000AA; d_we = 1'b0; d_req = 1'b1; c0 = cyc;
    repeat (4) @(negedge clk);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; d_addr = 24'h0000BB; d_req = 1'b1;
    at = -1; stale_ack = 1'b1; stale_rdata = 'x; dat = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cyc == c0 + 7) begin
        stale_ack = d_ack; stale_rdata = d_rdata;
      end
      if (d_ack && cyc != c0 + 7) begin
        at = cyc; dat = d_rdata;
        break;
      end
    end
    d_req = 1'b0;
    checks++;
    if (stale_ack !== 1'b0 || stale_rdata !== 16'h0000) begin
      errors++; $display("FAIL stale_ready: got ack %b rdata %h expected 0 0000", stale_ack, stale_rdata);
    end
    checks++;
    if (at - (c0 + 5) !== 10) begin
      errors++; $display("FAIL post_reset_latency: got %0d expected 10", at - (c0 + 5));
    end
    checks++;
    if (dat !== init_val(24'h0000BB)) begin
      errors++; $display("FAIL post_reset_data: got %h expected %h", dat, init_val(24'h0000BB));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n_rd - s_rd !== 3 || n_dack - s_dack !== 1) begin
      errors++; $display("FAIL post_reset_counts: got %0d strobes %0d acks expected 3 1",
                         n_rd - s_rd, n_dack - s_dack);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_fetch();
    test_refresh_retry();
    test_starvation();
    test_reset_mid_read();
    checks++;
    if (n_overlap !== 0) begin
      errors++; $display("FAIL ack_overlap: got %0d cycles with both acks expected 0", n_overlap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
